// File: rtl/riscv_pkg.sv
// Shared opcodes, loader FSM states and immediate range limits for the instruction packer.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN
  } pack_state_t;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int BR_MIN    = -4096;
  localparam int BR_MAX    = 4094;
  localparam int SHAMT_MIN = 0;
  localparam int SHAMT_MAX = 31;

  function automatic logic in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// 4-entry x 32-bit synchronous FIFO; push and pop may occur in the same cycle.
module instr_fifo (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] wdata,
  input  logic        pop,
  output logic [31:0] head,
  output logic        full,
  output logic        empty,
  output logic [2:0]  count
);

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // the pointers and count, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 3'd4);
  assign empty = (count == 3'd0);

endmodule

// File: rtl/instr_packer.sv
// Packs decoded instruction fields into RV32 words, buffers them and writes
// them to instruction memory at sequential word addresses.
module instr_packer
  import riscv_pkg::*;
#(
  parameter int unsigned   AW   = 32,
  parameter logic [AW-1:0] BASE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [6:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic [6:0]    in_funct7,
  input  logic [31:0]   in_imm,
  output logic          imem_we,
  input  logic          imem_ready,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    err_cnt
);

  pack_state_t   state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          err_q;
  logic [7:0]    err_cnt_q;

  logic [31:0]   word;
  logic          imm_ok;
  logic          fire, push, pop, reject;
  logic [31:0]   fifo_head;
  logic          fifo_full, fifo_empty;
  logic [2:0]    fifo_count;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    word   = '0;
    imm_ok = 1'b0;
    case (in_op)
      OP_BRANCH: begin
        word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], in_op};
        imm_ok = !in_imm[0] && in_range(in_imm, BR_MIN, BR_MAX);
      end
      OP_LOAD: begin
        word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        imm_ok = in_range(in_imm, IMM12_MIN, IMM12_MAX);
      end
      OP_IMM: begin
        if (in_funct3 == F3_SLL || in_funct3 == F3_SRX) begin
          word   = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
          imm_ok = in_range(in_imm, SHAMT_MIN, SHAMT_MAX);
        end else begin
          word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
          imm_ok = in_range(in_imm, IMM12_MIN, IMM12_MAX);
        end
      end
      OP_STORE: begin
        word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
        imm_ok = in_range(in_imm, IMM12_MIN, IMM12_MAX);
      end
      OP_REG: begin
        word   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
        imm_ok = 1'b1;
      end
      default: ;
    endcase
  end

  // No bypass: a full FIFO stalls input even if it pops this cycle.
  assign in_ready = (state_q == S_LOAD) && !fifo_full;
  assign fire     = in_valid && in_ready;
  assign push     = fire && imm_ok;
  assign reject   = fire && !imm_ok;
  assign pop      = imem_we && imem_ready;

  instr_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (word),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (fire && in_last) state_d = S_DRAIN;
      S_DRAIN: if (fifo_count == 3'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= BASE;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      addr_q    <= BASE;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (pop) addr_q <= addr_q + AW'(4);
      if (reject) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Head is masked while empty so the unreset storage never reaches the port.
  assign imem_we    = !fifo_empty;
  assign imem_wdata = fifo_empty ? '0 : fifo_head;
  assign imem_addr  = addr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DRAIN) && (fifo_count == 3'd0);
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_instr_packer.sv
// Directed self-checking bench for instr_packer; a second instance with a
// 4-bit address space shares the stimulus to exercise address wrap-around.
module tb_instr_packer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_last;
  logic [6:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        imem_ready;

  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  err_cnt;

  logic        w_in_ready;
  logic        w_imem_we;
  logic [3:0]  w_imem_addr;
  logic [31:0] w_imem_wdata;
  logic        w_busy;
  logic        w_done;
  logic        w_err;
  logic [7:0]  w_err_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int prev_done;

  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  w2_q [$];

  logic [31:0] bp_exp [6] = '{32'h0000_0093, 32'h0010_0113, 32'h0020_0193,
                              32'h0030_0213, 32'h0040_0293, 32'h0050_0313};

  instr_packer #(.AW(32), .BASE(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  instr_packer #(.AW(4), .BASE(4'd12)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (w_in_ready),
    .in_last    (in_last),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .imem_we    (w_imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (w_imem_addr),
    .imem_wdata (w_imem_wdata),
    .busy       (w_busy),
    .done       (w_done),
    .err        (w_err),
    .err_cnt    (w_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after posedge, so at negedge the handshake for the
  // coming edge is already settled.
  always @(negedge clk) begin
    if (!rst && imem_we && imem_ready) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
    end
    if (!rst && w_imem_we && imem_ready) w2_q.push_back(w_imem_addr);
    if (done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [31:0] s_imm(input logic [31:0] w);
    return {{20{w[31]}}, w[31:25], w[11:7]};
  endfunction

  function automatic logic [31:0] b_imm_half(input logic [31:0] w);
    return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic last);
    logic ok;
    ok        = 1'b0;
    in_op     = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_last   = last;
    in_valid  = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    int prev;
    prev = done_cnt;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (done_cnt != prev) break;
    end
    #1;
    repeat (2) tick();
    chk("done_pulse", 32'(done_cnt - prev), 32'd1);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready",  32'(in_ready),   32'd0);
    chk("rst_imem_we",   32'(imem_we),    32'd0);
    chk("rst_imem_addr", imem_addr,       32'd0);
    chk("rst_wdata",     imem_wdata,      32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_done",      32'(done),       32'd0);
    chk("rst_err",       32'(err),        32'd0);
    chk("rst_err_cnt",   32'(err_cnt),    32'd0);
    chk("rst_wrap_addr", 32'(w_imem_addr), 32'd12);
  endtask

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    w2_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; imem_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    chk_reset();
    rst = 1'b0;
    tick();

    // Store round-trip: sw x5, -4(x2)
    clear_logs();
    imem_ready = 1'b1;
    start_session();
    send(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 1'b1);
    wait_done();
    chk("st_count", 32'(wa_q.size()), 32'd1);
    chk("st_addr",  wa_q[0], 32'd0);
    chk("st_word",  wd_q[0], 32'hFE51_2E23);
    chk("st_imm",   s_imm(wd_q[0]), 32'hFFFF_FFFC);
    chk("st_err",   32'(err), 32'd0);
    chk("st_busy",  32'(busy), 32'd0);

    // Branch round-trip then an odd offset reject
    clear_logs();
    start_session();
    send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0);
    send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1);
    wait_done();
    chk("br_count",   32'(wa_q.size()), 32'd1);
    chk("br_word",    wd_q[0], 32'hFE20_8CE3);
    chk("br_imm",     b_imm_half(wd_q[0]), 32'hFFFF_FFFC);
    chk("br_err",     32'(err), 32'd1);
    chk("br_err_cnt", 32'(err_cnt), 32'd1);

    // Backpressure: six addi beats against a stalled memory
    clear_logs();
    imem_ready = 1'b0;
    start_session();
    chk("start_clr_err", 32'(err), 32'd0);
    chk("start_clr_cnt", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 4; i++)
      send(7'b0010011, 3'b000, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
    in_op = 7'b0010011; in_funct3 = 3'b000; in_rd = 5'd5; in_rs1 = 5'd0;
    in_imm = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_we",        32'(imem_we), 32'd1);
    chk("bp_addr",      imem_addr, 32'd0);
    chk("bp_wdata",     imem_wdata, bp_exp[0]);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_addr_hold",  imem_addr, 32'd0);
    chk("bp_wdata_hold", imem_wdata, bp_exp[0]);
    chk("bp_ready_hold", 32'(in_ready), 32'd0);
    tick();
    imem_ready = 1'b1;
    send(7'b0010011, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'd4, 1'b0);
    send(7'b0010011, 3'b000, 7'd0, 5'd6, 5'd0, 5'd0, 32'd5, 1'b1);
    wait_done();
    chk("bp_count", 32'(wa_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_addr_%0d", i), wa_q[i], 32'(4 * i));
      chk($sformatf("bp_word_%0d", i), wd_q[i], bp_exp[i]);
    end
    chk("bp_err", 32'(err), 32'd0);

    // Range edges
    clear_logs();
    start_session();
    send(7'b0010011, 3'b000, 7'd0, 5'd3, 5'd4, 5'd0, 32'd2047, 1'b0);
    send(7'b0010011, 3'b000, 7'd0, 5'd3, 5'd4, 5'd0, 32'd2048, 1'b0);
    send(7'b0010011, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32,   1'b0);
    send(7'b0010011, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd31,   1'b0);
    send(7'b1111111, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd0,    1'b1);
    wait_done();
    chk("rg_count",   32'(wa_q.size()), 32'd2);
    chk("rg_addi_w",  wd_q[0], 32'h7FF2_0193);
    chk("rg_slli_w",  wd_q[1], 32'h01F0_9093);
    chk("rg_addr1",   wa_q[1], 32'd4);
    chk("rg_err_cnt", 32'(err_cnt), 32'd3);
    chk("rg_err",     32'(err), 32'd1);

    // Saturation after 300 rejects
    clear_logs();
    start_session();
    for (int i = 0; i < 300; i++)
      send(7'b1111111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'(i == 299));
    wait_done();
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    chk("sat_writes",  32'(wa_q.size()), 32'd0);

    // Reset mid-session with three queued entries
    clear_logs();
    imem_ready = 1'b0;
    start_session();
    for (int i = 0; i < 3; i++)
      send(7'b0010011, 3'b000, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_we",   32'(imem_we), 32'd1);
    prev_done = done_cnt;
    rst = 1'b1;
    #1;
    chk_reset();
    tick();
    rst = 1'b0;
    imem_ready = 1'b1;
    repeat (3) tick();
    chk("mid_no_done",  32'(done_cnt - prev_done), 32'd0);
    chk("mid_no_write", 32'(wa_q.size()), 32'd0);
    start_session();
    send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1);
    wait_done();
    chk("mid_restart_cnt",  32'(wa_q.size()), 32'd1);
    chk("mid_restart_addr", wa_q[0], 32'd0);

    // Wrap-around on the 4-bit instance
    clear_logs();
    start_session();
    send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0);
    send(7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b1);
    wait_done();
    chk("wrap_count", 32'(w2_q.size()), 32'd2);
    chk("wrap_addr0", 32'(w2_q[0]), 32'd12);
    chk("wrap_addr1", 32'(w2_q[1]), 32'd0);
    chk("wide_addr1", wa_q[1], 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_packer.md
# instr_packer

Instruction packer and program loader: the encode-direction counterpart to `imm_gen`. Accepts decoded instruction fields plus a signed immediate over a valid/ready handshake. Range-checks the immediate, packs the fields into a 32-bit RV32 word, buffers the word in a 4-entry FIFO, and writes it into instruction memory at sequential word addresses. It sits between the test/boot loader and the instruction-memory write port, ahead of the pipeline fetch stage.

## Interface
- `AW`, 32: instruction-memory byte-address width.
- `BASE`, 0: first write address (word-aligned).
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `start  in  1`: begin a load session; only honoured in IDLE.
- `in_valid  in  1` / `in_ready  out  1`: field handshake.
- `in_last  in  1`: marks the final instruction of the session.
- `in_op  in  7`, `in_rd  in  5`, `in_rs1  in  5`, `in_rs2  in  5`, `in_funct3  in  3`, `in_funct7  in  7`: instruction fields.
- `in_imm  in  32`: signed immediate, in bytes for branches.
- `imem_we  out  1` / `imem_ready  in  1`: write handshake.
- `imem_addr  out  AW`: byte address of the write.
- `imem_wdata  out  32`: packed instruction word.
- `busy  out  1`: high when the state is not IDLE.
- `done  out  1`: one-cycle pulse at the end of a session.
- `err  out  1`: sticky reject flag; cleared on `start`.
- `err_cnt  out  8`: saturating count of rejected instructions; cleared on `start`.

## Operation
- FSM states: IDLE, LOAD, DRAIN.
  - IDLE→LOAD on `start`. This also sets addr=BASE and clears `err`/`err_cnt`.
  - LOAD→DRAIN on acceptance of a beat with `in_last`=1.
  - DRAIN→IDLE when the FIFO is empty. `done` pulses on that edge.
  - `start` in LOAD or DRAIN is ignored.
- `in_ready` = (state==LOAD) && FIFO count<4. There is no bypass: when the FIFO is full, `in_ready`=0 even if a pop occurs in the same cycle.
- Encoding by `in_op`:
  - 1100011 SB: word[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. Valid only if imm is even and in −4096..4094.
  - 0000011 load and 0010011 I-ALU: [31:20]=imm[11:0]. Valid range is −2048..2047.
  - 0010011 with funct3 001/101 (shift): [31:25]=funct7, [24:20]=imm[4:0]. Valid range is 0..31.
  - 0100011 store: [31:25]=imm[11:5], [11:7]=imm[4:0]. Valid range is −2048..2047.
  - 0110011 R-type: [31:25]=funct7, [24:20]=rs2. `in_imm` is ignored.
  - rd, rs1, rs2 and funct3 go in their standard RV32 positions where the format has them.
- Any other opcode, or an out-of-range immediate, is a reject:
  - the handshake still completes;
  - no FIFO push;
  - `err`←1 and `err_cnt`+1, saturating at 255.
  - A rejected `in_last` still moves the FSM to DRAIN.
- Round-trip property: `imm_gen`(packed word) equals `in_imm` for I, load and store formats, and equals `in_imm`>>>1 for SB.
- Write side:
  - `imem_we` = FIFO non-empty.
  - `imem_wdata` = FIFO head.
  - On `imem_we && imem_ready`: pop the FIFO and add 4 to addr, modulo 2^AW. Wrap-around is silent.

## Timing
- Reset values:
  - state=IDLE, FIFO empty, addr=BASE.
  - `in_ready`=0, `imem_we`=0, `imem_addr`=BASE, `imem_wdata`=0.
  - `busy`=0, `done`=0, `err`=0, `err_cnt`=0.
- Latency: a beat accepted at edge N is pushed at edge N. `imem_we` is high from cycle N+1, or later if older entries are queued.
- Sustained throughput is one word per cycle while `imem_ready`=1.
- `imem_addr`, `imem_wdata` and `imem_we` hold stable while `imem_ready`=0.
- Asserting `rst` mid-session aborts the session immediately. The FIFO is flushed, no `done` pulse is produced, and no further write is issued.
- `done` pulses on the edge where DRAIN sees the FIFO empty, at the earliest the cycle after the last pop.

## Structure
- `riscv_pkg` holds:
  - opcode localparams: OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG;
  - the state enum `pack_state_t`;
  - the immediate range constants.
- One sub-module, `instr_fifo`: a 4×32 synchronous FIFO with push, pop, full, empty and a 3-bit count.
- Encoding and range check are combinational inside `instr_packer`.

## Test plan
- Store round-trip: start; one beat with op=0100011, funct3=010, rs1=2, rs2=5, imm=−4, last=1.
  - Expect write at BASE of 0xFE512E23.
  - `imm_gen` returns 0xFFFFFFFC.
  - `done` pulses; `err`=0.
- Branch round-trip: op=1100011, funct3=000, rs1=1, rs2=2, imm=−8.
  - Expect word 0xFE208CE3 and `imm_gen` output 0xFFFFFFFC.
  - With imm=7 (odd): no write, `err`=1, `err_cnt`=1.
- Backpressure: 6 consecutive addi beats with `imem_ready`=0.
  - `in_ready` drops after 4 accepted.
  - Release `imem_ready`: 6 writes at BASE, +4 … +20, in order.
- Range edges:
  - addi imm=2047 is written.
  - addi imm=2048 is rejected.
  - slli imm=32 is rejected.
  - unknown op 1111111 is rejected.
  - After 300 rejects `err_cnt` stays at 255.
- Reset mid-session: `rst` asserted while the FIFO holds 3 entries.
  - All outputs at reset values next cycle; no `done`.
  - A new `start` writes from BASE.
- Wrap-around: AW=4, BASE=12; two beats.
  - Writes go to 12 and then 0.
